pipe_stage_skid: RTL
====================

Name: pipe_stage_skid

Overview:
- Generic pipeline-stage register for ID/EX-style stage boundaries, carrying a control bundle and a data bundle.
- Adds valid/ready flow control with a 2-entry skid buffer, so full throughput holds while upstream ready stays registered.
- Separates "flush" (inject bubble) from back-pressure (hold contents). The older stage register merged these into a single reset-like pause.

Parameters:
CTRL_W, 16, width of control bundle (reg_en, mem_en, alu ops, ...)
DATA_W, 64, width of data bundle (operands, immediate, pc+2, ...)
BUBBLE_CTRL, {CTRL_W{1'b0}}, control value presented whenever no valid entry is at the output (decodes as NOP)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  synchronous: discard all held entries and any same-cycle input
in_valid  in  1  upstream has an entry
in_ready  out  1  stage can accept; registered (function of state only)
in_ctrl  in  CTRL_W  upstream control bundle
in_data  in  DATA_W  upstream data bundle
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts (low = stall)
out_ctrl  out  CTRL_W  head-entry control; BUBBLE_CTRL when out_valid=0
out_data  out  DATA_W  head-entry data; 0 when out_valid=0
occupancy  out  2  entries held: 0, 1 or 2

Behaviour:
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage: main slot drives the outputs; skid slot holds the overflow entry. Outputs come straight from registers; there is no combinational path from in_* to out_*.
- States are EMPTY (occ 0), ONE (occ 1) and TWO (occ 2). in_ready=1 in EMPTY and ONE, 0 in TWO. out_valid=1 in ONE and TWO.
- State transitions (flush=0, rst=0):
  - EMPTY: in_fire -> ONE, main<=in.
  - ONE, in_fire & out_fire -> ONE, main<=in.
  - ONE, in_fire only -> TWO, skid<=in, main held.
  - ONE, out_fire only -> EMPTY, main<=bubble.
  - ONE, neither -> hold.
  - TWO, out_fire -> ONE, main<=skid, skid<=bubble.
  - TWO, no out_fire -> hold. in_fire is impossible in TWO.
- Bubble means ctrl=BUBBLE_CTRL and data=0.
- Latency: 1 cycle from in_fire to out_valid when EMPTY. Sustained throughput is 1 entry/cycle with out_ready held high.
- Ordering: strictly FIFO. The skid entry is never presented before the main entry.
- Stall: while out_valid=1 and out_ready=0, out_ctrl and out_data hold stable, and out_valid never drops without out_fire or flush.
- flush=1 (priority over all handshakes except rst):
  - Next state is EMPTY; both slots <= bubble.
  - A same-cycle in_fire is dropped. Upstream sees the handshake complete, and the entry is not presented.
  - A same-cycle out_fire still counts as consumed downstream.
- rst=1 (highest priority): same end state as flush, so out_valid=0, in_ready=1 next cycle, occupancy=0, out_ctrl=BUBBLE_CTRL, out_data=0.
- Reset or flush mid-operation in TWO discards both entries, with no partial drain.
- Reset values: out_valid=0, in_ready=1, occupancy=0, out_ctrl=BUBBLE_CTRL, out_data=0.
- No X propagation: held ctrl/data are bubble whenever the corresponding slot is empty.

Decomposition:
- Shared package pipe_pkg holds:
  - the occupancy state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2);
  - the default bubble constant.
- Sub-module pipe_slot is a single CTRL_W+DATA_W register with load and clear-to-bubble controls. It is instantiated twice (main, skid).
- The parent holds the state machine and slot muxing.

Test Plan:
1. rst held 2 cycles, then released -> out_valid=0, in_ready=1, occupancy=0, out_ctrl=BUBBLE_CTRL, out_data=0.
2. out_ready=1; feed ctrl=0x0001..0x0004 on consecutive cycles with in_valid=1 -> each appears 1 cycle later in order, occupancy stays 1, in_ready stays 1.
3. Stall fill:
   - Set out_ready=0 after 0x0010 enters, then offer 0x0011 -> occupancy=2, in_ready=0, and out_ctrl holds 0x0010.
   - Raise out_ready -> 0x0010 then 0x0011 out on consecutive cycles, occupancy 2->1->0.
4. In TWO (0x0020 main, 0x0021 skid), pulse flush -> next cycle occupancy=0, out_valid=0, out_ctrl=BUBBLE_CTRL; 0x0021 never appears.
5. In ONE, flush asserted with in_valid=1 carrying 0x0030 -> 0x0030 dropped, out_valid=0 next cycle.
6. rst asserted in TWO with out_ready=0 -> next cycle all reset values. The first entry accepted after release emerges with 1-cycle latency.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline stage.
package pipe_pkg;

  // Occupancy encoding; the state value is also the occupancy output.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  // Bit replicated across the control bundle to form the default bubble (NOP).
  localparam logic BUBBLE_BIT = 1'b0;

endpackage

// File: rtl/pipe_slot.sv
// One ctrl+data holding register with load and clear-to-bubble.
module pipe_slot #(
  parameter int                CTRL_W      = 16,
  parameter int                DATA_W      = 64,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              ld_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  // Clear beats load so an empty slot never holds stale or X contents.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      ctrl_q <= BUBBLE_CTRL;
      data_q <= '0;
    end else if (ld_i) begin
      ctrl_q <= ctrl_i;
      data_q <= data_i;
    end
  end

  assign ctrl_o = ctrl_q;
  assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready, a 2-entry skid buffer and a
// flush that injects a bubble independently of back-pressure.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                CTRL_W      = 16,
  parameter int                DATA_W      = 64,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{BUBBLE_BIT}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  occ_e state_q, state_d;

  logic main_ld, main_clr, main_from_skid;
  logic skid_ld, skid_clr;
  logic in_fire, out_fire;

  logic [CTRL_W-1:0] skid_ctrl, main_ctrl_d;
  logic [DATA_W-1:0] skid_data, main_data_d;

  // Handshake signals depend only on the state register.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign occupancy = state_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Next state and slot controls; flush empties both slots and drops any input.
  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_d  = EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: if (in_fire) begin
          state_d = ONE;
          main_ld = 1'b1;
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_ld = 1'b1;
          end else if (in_fire) begin
            state_d = TWO;
            skid_ld = 1'b1;
          end else if (out_fire) begin
            state_d  = EMPTY;
            main_clr = 1'b1;
          end
        end
        TWO: if (out_fire) begin
          state_d        = ONE;
          main_ld        = 1'b1;
          main_from_skid = 1'b1;
          skid_clr       = 1'b1;
        end
        default: begin
          state_d  = EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  assign main_ctrl_d = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_data_d = main_from_skid ? skid_data : in_data;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .BUBBLE_CTRL(BUBBLE_CTRL)) u_main (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (main_clr),
    .ld_i   (main_ld),
    .ctrl_i (main_ctrl_d),
    .data_i (main_data_d),
    .ctrl_o (out_ctrl),
    .data_o (out_data)
  );

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .BUBBLE_CTRL(BUBBLE_CTRL)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (skid_clr),
    .ld_i   (skid_ld),
    .ctrl_i (in_ctrl),
    .data_i (in_data),
    .ctrl_o (skid_ctrl),
    .data_o (skid_data)
  );

endmodule
